// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian host packet path.
// Opcode bytes sit in the top byte of each source's packet.
package ucaspian_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    localparam int MAX_PKT_BYTES = 4;

    localparam logic [7:0] OP_FIRE   = 8'h10;
    localparam logic [7:0] OP_METRIC = 8'h20;
    localparam logic [7:0] OP_ACK    = 8'h30;
    localparam logic [7:0] OP_TIME   = 8'h40;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or above ptr,
// wrapping modulo NUM_SRC. Gives one-hot grant and binary index.
module rr_arbiter
    import ucaspian_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IW-1:0]      idx
);

    int          pos;
    logic [IW-1:0] p;
    logic        hit;

    // Scan from ptr upward; the first requester found wins
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        pos   = 0;
        p     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = (int'(ptr) + k) % NUM_SRC;
            p   = IW'(pos);
            if (!hit && req[p]) begin
                hit      = 1'b1;
                grant[p] = 1'b1;
                idx      = p;
            end
        end
    end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter serialising whole packets from several sources
// onto the byte-wide host TX stream, MSB byte first.
module tx_packet_arbiter
    import ucaspian_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BYTES = MAX_PKT_BYTES,
    parameter int LW        = $clog2(MAX_BYTES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           req_vld,
    input  logic [NUM_SRC*LW-1:0]        req_len,
    input  logic [NUM_SRC*MAX_BYTES*8-1:0] req_data,
    output logic [NUM_SRC-1:0]           req_ack,
    output logic [7:0]                   tx_data,
    output logic                         tx_vld,
    input  logic                         tx_rdy,
    output logic                         busy,
    output logic [$clog2(NUM_SRC)-1:0]   grant_idx
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int DW = MAX_BYTES * 8;

    tx_state_t    state, state_n;
    logic [DW-1:0] shift, shift_n, pick;
    logic [LW-1:0] len, len_n, cnt, cnt_n, pick_len;
    logic [IW-1:0] rr_ptr, rr_n, grant_n, win;
    logic [NUM_SRC-1:0] win_oh, ack_n;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_rr (
        .req   (req_vld),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .idx   (win)
    );

    // AND-OR mux of the winning source's packet and length
    always_comb begin
        pick     = '0;
        pick_len = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_oh[i]) begin
                pick     = pick | req_data[i*DW +: DW];
                pick_len = pick_len | req_len[i*LW +: LW];
            end
        end
    end

    // Next-state logic: grant in IDLE, shift bytes out in SEND
    always_comb begin
        state_n = state;
        shift_n = shift;
        len_n   = len;
        cnt_n   = cnt;
        grant_n = grant_idx;
        rr_n    = rr_ptr;
        ack_n   = '0;
        unique case (state)
            IDLE: begin
                if (|req_vld) begin
                    state_n = SEND;
                    shift_n = pick;
                    len_n   = pick_len;
                    cnt_n   = '0;
                    grant_n = win;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    if (cnt == len) begin
                        ack_n[grant_idx] = 1'b1;
                        rr_n    = (grant_idx == IW'(NUM_SRC-1))
                                ? '0 : grant_idx + IW'(1);
                        shift_n = '0;
                        state_n = IDLE;
                    end else begin
                        shift_n = shift << 8;
                        cnt_n   = cnt + LW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            len       <= '0;
            cnt       <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            req_ack   <= '0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            len       <= len_n;
            cnt       <= cnt_n;
            grant_idx <= grant_n;
            rr_ptr    <= rr_n;
            req_ack   <= ack_n;
        end
    end

    assign tx_vld  = (state == SEND);
    assign busy    = (state == SEND);
    assign tx_data = shift[DW-1 -: 8];

endmodule
